input_conditioner_bank: RTL and testbench
=========================================

# input_conditioner_bank

Multi-channel, parametrised input conditioner for the lab board's switch and button inputs. Each channel synchronises an asynchronous input into the `clk` domain, debounces it with a configurable stability window, and emits one-cycle rising and falling edge pulses. Sticky per-channel event flags, with a software clear, are added so a slower consumer (FSM or register file) cannot miss a pulse. It sits between the raw board pins and the datapath control logic.

## Interface
- `CHANNELS`, 8: number of independent input channels; legal values are 1 to 32.
- `WAITTIME`, 3: debounce window in clock cycles; legal minimum is 1.
- `COUNTERWIDTH`, 3: width of each channel's debounce counter; must satisfy 2^COUNTERWIDTH > WAITTIME.
- `SYNCSTAGES`, 2: number of synchroniser flops per channel; legal minimum is 2.
- `RESETVALUE`, 0: idle level of the inputs. Synchroniser flops and `conditioned` load this value on reset.

Ports:
- `clk`, in, 1: single clock domain.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `noisysignal`, in, CHANNELS: raw asynchronous inputs.
- `eventclear`, in, CHANNELS: per-channel clear mask for `eventflag`.
- `conditioned`, out, CHANNELS: debounced, synchronised level.
- `positiveedge`, out, CHANNELS: one-cycle pulse on a rising transition of `conditioned`.
- `negativeedge`, out, CHANNELS: one-cycle pulse on a falling transition of `conditioned`.
- `eventflag`, out, CHANNELS: sticky flag; set by either edge, held until cleared.
- `anyedge`, out, 1: OR of all `positiveedge` and `negativeedge` bits in the current cycle.

## Operation
- **Synchroniser.** Each channel has a SYNCSTAGES-deep shift register. `syncout` is the last stage.
- **Debounce.** The following rules are evaluated every posedge:
  - If `syncout == conditioned`, the counter clears to 0 and the edge outputs are 0.
  - Else, if `counter == WAITTIME`:
    - the counter clears to 0;
    - `conditioned` takes `syncout`;
    - the matching edge output is 1 for exactly this cycle.
  - Else, the counter increments and the edge outputs are 0.
- **Glitch rejection.** Any return of `syncout` to the `conditioned` level before the counter reaches WAITTIME restarts the window from 0.
- **Counter range.** The counter never exceeds WAITTIME, so no wrap-around can occur.
- **Edge exclusivity.** `positiveedge` and `negativeedge` are never both high on the same channel in the same cycle.
- **`eventflag` update.** Each bit is registered with the next value `(eventflag & ~eventclear) | positiveedge | negativeedge`.
  - Set has priority: if clear and an edge arrive in the same cycle, the flag stays 1.
- **`anyedge`.** Combinational OR of the registered edge outputs. It adds no flop.
- **Channel independence.** Activity on one channel never affects the counter or outputs of any other channel.
- **Reset.** While `rst_n` is low:
  - all synchroniser flops and `conditioned` are `RESETVALUE`;
  - counters are 0;
  - `positiveedge`, `negativeedge`, `eventflag` and `anyedge` are 0.
- **Reset mid-operation.** Assertion takes effect immediately and abandons any count in progress. No edge pulse is generated by reset entry or exit.

## Timing
- **Conditioning latency.** Let posedge k be the first posedge at which a stable new level is sampled into stage 0. Then `conditioned` and the edge pulse update at posedge k + SYNCSTAGES + WAITTIME.
  - With the defaults, that is 5 posedges after first sampling.
- **Minimum accepted pulse.** An input level must be held for at least WAITTIME + 1 consecutive samples at `syncout` to be accepted. Shorter pulses produce no output activity.
- **Pulse width.** Each edge pulse is exactly 1 cycle wide.
- **`eventflag` timing.** The flag rises 1 cycle after the edge pulse. It falls 1 cycle after `eventclear` is sampled high, provided no coincident edge.
- **Back-to-back transitions.** After a transition, the earliest opposite transition on the same channel is WAITTIME + 1 cycles later.
- **Reset release.** `rst_n` deassertion is synchronised externally. The block assumes release meets recovery timing to `clk`.

## Structure
- **Shared package `inputcond_pkg`.** Holds a `clog2` function and a checker for COUNTERWIDTH ≥ clog2(WAITTIME + 1). The top module fails elaboration if the check fails.
- **Sub-module `inputcond_channel`.** Contains one channel's synchroniser, counter and edge logic. It is instantiated CHANNELS times by a generate loop.
- **Top module.** `eventflag` and `anyedge` logic lives in the top module.

## Test plan
- **Reset.** Drive `rst_n` = 0 with `noisysignal` = 8'hFF, then release. Required:
  - all outputs are 0 during reset;
  - `conditioned` = 8'hFF after 5 cycles;
  - 8 `positiveedge` pulses in one cycle;
  - `anyedge` = 1 for 1 cycle.
- **Clean step.** Channel 0 goes 0→1 and is held. Required:
  - `positiveedge[0]` high for exactly 1 cycle, 5 posedges after first sampling;
  - `eventflag[0]` = 1 on the next cycle.
- **Bounce.** Channel 3 toggles every 2 cycles for 20 cycles, then holds 1. Required:
  - no output change during the toggling;
  - a single `positiveedge[3]` 5 cycles after the final sample.
- **Clear vs set.** Assert `eventclear[0]` in the same cycle as `negativeedge[0]`. Required:
  - `eventflag[0]` stays 1;
  - asserting `eventclear[0]` alone on the following cycle clears it to 0.
- **Reset mid-count.** Assert `rst_n` low while channel 5's counter is at 2. Required:
  - counter 0 and `conditioned[5]` = 0 immediately;
  - no pulse on release.
- **Independence.** Channels 1 and 6 step on the same cycle, and channel 2 glitches 1 cycle. Required:
  - edge pulses on channels 1 and 6 only;
  - channel 2 output unchanged.

Source files
------------

// File: rtl/inputcond_pkg.sv
// inputcond_pkg: shared helpers for the input conditioner bank
package inputcond_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Counter must be wide enough to reach WAITTIME without wrapping
  function automatic bit width_ok(input int waittime, input int width);
    return width >= clog2(waittime + 1);
  endfunction

endpackage

// File: rtl/inputcond_channel.sv
// inputcond_channel: one channel's synchroniser, debounce counter and edge pulses
module inputcond_channel
  import inputcond_pkg::*;
#(
  parameter int   WAITTIME     = 3,
  parameter int   COUNTERWIDTH = 3,
  parameter int   SYNCSTAGES   = 2,
  parameter logic RESETVALUE   = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic noisy_i,
  output logic cond_o,
  output logic pos_o,
  output logic neg_o
);

  localparam logic [COUNTERWIDTH-1:0] WAIT = COUNTERWIDTH'(WAITTIME);

  logic [SYNCSTAGES-1:0]   sync_q;
  logic [COUNTERWIDTH-1:0] cnt_q, cnt_d;
  logic                    cond_q, cond_d, pos_q, pos_d, neg_q, neg_d;
  logic                    syncout, diff, hit;

  assign syncout = sync_q[SYNCSTAGES-1];

  // Debounce: a differing level must survive a full window before it is taken
  always_comb begin
    diff   = syncout != cond_q;
    hit    = diff && (cnt_q == WAIT);
    cnt_d  = (!diff || hit) ? '0 : cnt_q + 1'b1;
    cond_d = hit ? syncout : cond_q;
    pos_d  = hit && syncout;
    neg_d  = hit && !syncout;
  end

  // Synchroniser shift and debounce state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SYNCSTAGES{RESETVALUE}};
      cnt_q  <= '0;
      cond_q <= RESETVALUE;
      pos_q  <= 1'b0;
      neg_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNCSTAGES-2:0], noisy_i};
      cnt_q  <= cnt_d;
      cond_q <= cond_d;
      pos_q  <= pos_d;
      neg_q  <= neg_d;
    end
  end

  assign cond_o = cond_q;
  assign pos_o  = pos_q;
  assign neg_o  = neg_q;

endmodule

// File: rtl/input_conditioner_bank.sv
// input_conditioner_bank: multi-channel synchronise/debounce/edge-detect with sticky event flags
module input_conditioner_bank
  import inputcond_pkg::*;
#(
  parameter int   CHANNELS     = 8,
  parameter int   WAITTIME     = 3,
  parameter int   COUNTERWIDTH = 3,
  parameter int   SYNCSTAGES   = 2,
  parameter logic RESETVALUE   = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] noisysignal,
  input  logic [CHANNELS-1:0] eventclear,
  output logic [CHANNELS-1:0] conditioned,
  output logic [CHANNELS-1:0] positiveedge,
  output logic [CHANNELS-1:0] negativeedge,
  output logic [CHANNELS-1:0] eventflag,
  output logic                anyedge
);

  if (!width_ok(WAITTIME, COUNTERWIDTH)) begin : g_bad_width
    $error("COUNTERWIDTH too narrow for WAITTIME");
  end

  logic [CHANNELS-1:0] flag_q, flag_d;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    inputcond_channel #(
      .WAITTIME    (WAITTIME),
      .COUNTERWIDTH(COUNTERWIDTH),
      .SYNCSTAGES  (SYNCSTAGES),
      .RESETVALUE  (RESETVALUE)
    ) u_ch (
      .clk    (clk),
      .rst_n  (rst_n),
      .noisy_i(noisysignal[i]),
      .cond_o (conditioned[i]),
      .pos_o  (positiveedge[i]),
      .neg_o  (negativeedge[i])
    );
  end

  // Sticky flags: an edge wins over a coincident clear
  always_comb flag_d = (flag_q & ~eventclear) | positiveedge | negativeedge;

  // Event flag register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) flag_q <= '0;
    else flag_q <= flag_d;
  end

  assign eventflag = flag_q;
  assign anyedge   = |(positiveedge | negativeedge);

endmodule

// File: tb/tb_input_conditioner_bank.sv
// tb_input_conditioner_bank: randomized and directed checks against a sample-history model
module tb_input_conditioner_bank;

  localparam int   CH = 8;
  localparam int   W  = 3;
  localparam int   CW = 3;
  localparam int   S  = 2;
  localparam logic RV = 1'b0;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [CH-1:0] noisysignal = '0;
  logic [CH-1:0] eventclear = '0;
  logic [CH-1:0] conditioned, positiveedge, negativeedge, eventflag;
  logic          anyedge;
  int            checks = 0;
  int            errors = 0;

  input_conditioner_bank #(
    .CHANNELS(CH), .WAITTIME(W), .COUNTERWIDTH(CW), .SYNCSTAGES(S), .RESETVALUE(RV)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .noisysignal(noisysignal), .eventclear(eventclear),
    .conditioned(conditioned), .positiveedge(positiveedge), .negativeedge(negativeedge),
    .eventflag(eventflag), .anyedge(anyedge)
  );

  always #5 clk = ~clk;

  wire [4*CH:0] outs = {conditioned, positiveedge, negativeedge, eventflag, anyedge};

  // Model: every input sample since reset; the debouncer sees the sample taken S posedges ago,
  // and a new level is accepted once the last W+1 seen samples all differ from the held level.
  logic [CH-1:0] samp[$];
  logic [CH-1:0] cond_m = '0, pos_m = '0, neg_m = '0, flag_m = '0;

  function automatic logic [CH-1:0] accept_mask();
    logic [CH-1:0] acc;
    int            n, idx;
    logic          b;
    n = samp.size();
    for (int c = 0; c < CH; c++) begin
      acc[c] = 1'b1;
      for (int j = 0; j <= W; j++) begin
        idx = n - j - S;
        b = (idx >= 0) ? samp[idx][c] : RV;
        if (b == cond_m[c]) acc[c] = 1'b0;
      end
    end
    return acc;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samp.delete();
      cond_m <= {CH{RV}};
      pos_m  <= '0;
      neg_m  <= '0;
      flag_m <= '0;
    end else begin
      flag_m <= (flag_m & ~eventclear) | pos_m | neg_m;
      pos_m  <= accept_mask() & ~cond_m;
      neg_m  <= accept_mask() & cond_m;
      cond_m <= cond_m ^ accept_mask();
      samp.push_back(noisysignal);
    end
  end

  function automatic logic [4*CH:0] exp_vec();
    return {cond_m, pos_m, neg_m, flag_m, |(pos_m | neg_m)};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    noisysignal = '1;
    eventclear = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (outs !== '0) begin errors++; $display("FAIL reset_hold got %h exp 0", outs); end
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (outs !== exp_vec()) begin errors++; $display("FAIL reset_model i=%0d got %h exp %h", i, outs, exp_vec()); end
      if (i == 4) begin
        checks++;
        if (conditioned !== 8'h00) begin errors++; $display("FAIL reset_early got %h exp 00", conditioned); end
      end
      if (i == 5) begin
        checks++;
        if ({conditioned, positiveedge, anyedge} !== {8'hFF, 8'hFF, 1'b1}) begin
          errors++; $display("FAIL reset_rise got %h/%h/%b exp ff/ff/1", conditioned, positiveedge, anyedge);
        end
      end
      if (i == 6) begin
        checks++;
        if ({anyedge, eventflag} !== {1'b0, 8'hFF}) begin
          errors++; $display("FAIL reset_after got %b/%h exp 0/ff", anyedge, eventflag);
        end
      end
    end
  endtask

  task automatic test_step();
    noisysignal = '0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (outs !== exp_vec()) begin errors++; $display("FAIL step_fall i=%0d got %h exp %h", i, outs, exp_vec()); end
    end
    eventclear = '1;
    @(negedge clk);
    eventclear = '0;
    checks++;
    if (eventflag !== 8'h00) begin errors++; $display("FAIL step_clear got %h exp 00", eventflag); end
    noisysignal[0] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (outs !== exp_vec()) begin errors++; $display("FAIL step_model i=%0d got %h exp %h", i, outs, exp_vec()); end
      checks++;
      if (positiveedge[0] !== (i == 5)) begin errors++; $display("FAIL step_pulse i=%0d got %b exp %b", i, positiveedge[0], i == 5); end
      checks++;
      if (eventflag[0] !== (i >= 6)) begin errors++; $display("FAIL step_flag i=%0d got %b exp %b", i, eventflag[0], i >= 6); end
    end
  endtask

  task automatic test_bounce();
    int pulses;
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      noisysignal[3] = (i >= 20) || ((i / 2) % 2 == 0);
      @(negedge clk);
      pulses += int'(positiveedge[3]);
      checks++;
      if (outs !== exp_vec()) begin errors++; $display("FAIL bounce_model i=%0d got %h exp %h", i, outs, exp_vec()); end
      checks++;
      if ({conditioned[3], positiveedge[3], negativeedge[3]} !== {i >= 25, i == 25, 1'b0}) begin
        errors++; $display("FAIL bounce_ch3 i=%0d got %b%b%b exp %b%b0", i,
                           conditioned[3], positiveedge[3], negativeedge[3], i >= 25, i == 25);
      end
    end
    checks++;
    if (pulses != 1) begin errors++; $display("FAIL bounce_count got %0d exp 1", pulses); end
  endtask

  task automatic test_clear_vs_set();
    noisysignal[0] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (outs !== exp_vec()) begin errors++; $display("FAIL clr_model i=%0d got %h exp %h", i, outs, exp_vec()); end
      if (i == 5) begin
        checks++;
        if ({negativeedge[0], eventflag[0]} !== 2'b11) begin errors++; $display("FAIL clr_edge got %b%b exp 11", negativeedge[0], eventflag[0]); end
        eventclear[0] = 1'b1;
      end
      if (i == 6) begin
        checks++;
        if (eventflag[0] !== 1'b1) begin errors++; $display("FAIL clr_setwins got %b exp 1", eventflag[0]); end
      end
      if (i == 7) begin
        checks++;
        if (eventflag[0] !== 1'b0) begin errors++; $display("FAIL clr_alone got %b exp 0", eventflag[0]); end
        eventclear[0] = 1'b0;
      end
    end
  endtask

  task automatic test_reset_mid();
    noisysignal[5] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (outs !== exp_vec()) begin errors++; $display("FAIL mid_model i=%0d got %h exp %h", i, outs, exp_vec()); end
    end
    checks++;
    if (u_dut.g_ch[5].u_ch.cnt_q !== 3'd2) begin errors++; $display("FAIL mid_count got %0d exp 2", u_dut.g_ch[5].u_ch.cnt_q); end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({u_dut.g_ch[5].u_ch.cnt_q, outs} !== '0) begin
      errors++; $display("FAIL mid_reset got %0d/%h exp 0/0", u_dut.g_ch[5].u_ch.cnt_q, outs);
    end
    noisysignal = '0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if ({outs, anyedge} !== {exp_vec(), 1'b0}) begin errors++; $display("FAIL mid_release i=%0d got %h exp %h", i, outs, exp_vec()); end
    end
  endtask

  task automatic test_independence();
    noisysignal = 8'h46;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      noisysignal = 8'h42;
      checks++;
      if (outs !== exp_vec()) begin errors++; $display("FAIL indep_model i=%0d got %h exp %h", i, outs, exp_vec()); end
      checks++;
      if ({positiveedge, negativeedge, conditioned[2]} !== {(i == 5) ? 8'h42 : 8'h00, 8'h00, 1'b0}) begin
        errors++; $display("FAIL indep_edges i=%0d got %h/%h/%b", i, positiveedge, negativeedge, conditioned[2]);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      for (int c = 0; c < CH; c++) if ($urandom_range(5) == 0) noisysignal[c] = ~noisysignal[c];
      eventclear = ($urandom_range(3) == 0) ? CH'($urandom) : '0;
      @(negedge clk);
      checks++;
      if (outs !== exp_vec()) begin errors++; $display("FAIL random i=%0d got %h exp %h", i, outs, exp_vec()); end
    end
    eventclear = '0;
  endtask

  initial begin
    test_reset();
    test_step();
    test_bounce();
    test_clear_vs_set();
    test_reset_mid();
    test_independence();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
